speed_selector: RTL and testbench

SPEED_SELECTOR -- requirements
Module: speed_selector

---
 rtl/speed_selector.sv | 199 +++++++++++++++++++
 tb/tb_speed_selector.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_selector.sv
// -----------------------------------------------------------------------------
// speed_selector
//
// Three-button speed selector for a PWM fan/motor stage. Raw push buttons
// are synchronised and debounced. Each press moves a 2-bit target level:
// stop > up > down when presses coincide. The registered duty_cycle output
// follows that target.
//
// Optional feature macro: SPEED_SOFT_START_EN
//   defined   : increases of the target are ramped one level per RAMP_CYCLES
//               cycles by an IDLE/RAMP controller; decreases apply at once.
//   undefined : duty_cycle loads the new target directly, busy is tied low
//               and no ramp timer exists.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronised samples needed to
//                     accept a button level change (>= 2)
//   RAMP_CYCLES     : dwell cycles per level step during soft start (>= 2)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   btn_up     : raw asynchronous "faster" button, active high
//   btn_down   : raw asynchronous "slower" button, active high
//   btn_stop   : raw asynchronous "stop" button, active high
//   duty_cycle : registered level code (0=off, 1=75%, 2=87.5%, 3=99%)
//   busy       : duty_cycle has not yet reached the target level
//   level_chg  : one-cycle pulse in the cycle after duty_cycle changes
// -----------------------------------------------------------------------------
module speed_selector #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_CYCLES     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  output logic [1:0] duty_cycle,
  output logic       busy,
  output logic       level_chg
);

  // Bit positions of the buttons inside the packed button vectors.
  localparam int B_DOWN = 0;
  localparam int B_UP   = 1;
  localparam int B_STOP = 2;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  // Reject illegal parameter values at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || RAMP_CYCLES < 2) begin : g_param_check
    $error("speed_selector: DEBOUNCE_CYCLES and RAMP_CYCLES must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser, debounce and press detection
  // ---------------------------------------------------------------------------
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_prev;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  assign raw = {btn_stop, btn_up, btn_down};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      // NOTE: the counter array is real state that must restart from zero so
      // a reset abandons any debounce in progress; it is cleared element-wise.
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let sync1->sync2 behave as two flops;
      // blocking here would collapse the synchroniser into a single stage.
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          // Stable for DEBOUNCE_CYCLES samples: accept the new level.
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Only the rising edge of the debounced level is an event; releases and
  // long holds produce nothing further.
  assign press = deb & ~deb_prev;

  // ---------------------------------------------------------------------------
  // Target level with stop > up > down priority
  // ---------------------------------------------------------------------------
  logic [1:0] target;
  logic [1:0] target_nxt;

  always_comb begin
    // NOTE: every path assigns target_nxt because of this default, so no
    // latch is inferred.
    target_nxt = target;
    if (press[B_STOP]) begin
      target_nxt = 2'd0;
    end else if (press[B_UP]) begin
      target_nxt = (target == 2'd3) ? 2'd3 : target + 2'd1;
    end else if (press[B_DOWN]) begin
      target_nxt = (target == 2'd0) ? 2'd0 : target - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output controller
  // ---------------------------------------------------------------------------
  logic [1:0] duty_nxt;

`ifdef SPEED_SOFT_START_EN
  localparam int RW = $clog2(RAMP_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,  // duty_cycle == target
    S_RAMP = 1'b1   // duty_cycle <  target, stepping up
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] ramp_timer;
  logic [RW-1:0] timer_nxt;

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_cycle;
    timer_nxt = ramp_timer;
    if (target_nxt < duty_cycle) begin
      // Slowing down is never ramped, whatever the current state.
      duty_nxt  = target_nxt;
      state_nxt = S_IDLE;
      timer_nxt = '0;
    end else if (state == S_IDLE) begin
      if (target_nxt > duty_cycle) begin
        state_nxt = S_RAMP;
        timer_nxt = '0;
      end
    end else if (target_nxt == duty_cycle) begin
      // A stop that lands exactly on the current level ends the ramp.
      state_nxt = S_IDLE;
      timer_nxt = '0;
    end else if (ramp_timer == RW'(RAMP_CYCLES - 1)) begin
      duty_nxt  = duty_cycle + 2'd1;
      timer_nxt = '0;
      if (duty_cycle + 2'd1 == target_nxt) begin
        state_nxt = S_IDLE;
      end
    end else begin
      // Further up presses only raise the target; the timer keeps running.
      timer_nxt = ramp_timer + RW'(1);
    end
  end

  assign busy = (duty_cycle != target);
`else
  // Without soft start the output tracks the target on the same edge.
  assign duty_nxt = target_nxt;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      target     <= 2'd0;
      duty_cycle <= 2'd0;
      level_chg  <= 1'b0;
`ifdef SPEED_SOFT_START_EN
      state      <= S_IDLE;
      ramp_timer <= '0;
`endif
    end else begin
      target     <= target_nxt;
      duty_cycle <= duty_nxt;
      // High while the freshly loaded duty_cycle differs from its old value.
      level_chg  <= (duty_nxt != duty_cycle);
`ifdef SPEED_SOFT_START_EN
      state      <= state_nxt;
      ramp_timer <= timer_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_speed_selector.sv
// -----------------------------------------------------------------------------
// tb_speed_selector
//
// Self-checking bench for speed_selector with DEBOUNCE_CYCLES=4 and
// RAMP_CYCLES=8. Covers reset behaviour, press timing, bounce rejection,
// priority and saturation (table driven), reset during debounce/ramp, and,
// in the default build, random button activity against a reference model.
// Soft-start sequences are included when SPEED_SOFT_START_EN is defined.
// -----------------------------------------------------------------------------
module tb_speed_selector;

  localparam int DEB  = 4;
  localparam int RAMP = 8;
`ifdef SPEED_SOFT_START_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_stop = 1'b0;
  logic [1:0] duty_cycle;
  logic       busy;
  logic       level_chg;

  int n_cmp = 0;
  int n_bad = 0;

  speed_selector #(
    .DEBOUNCE_CYCLES(DEB),
    .RAMP_CYCLES    (RAMP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_stop  (btn_stop),
    .duty_cycle(duty_cycle),
    .busy      (busy),
    .level_chg (level_chg)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_stop = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_duty"}, duty_cycle, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_lvl"}, level_chg, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (default build): the synchronised sample seen at an edge
  // is the raw value sampled two edges earlier; a button's debounced level
  // flips once the last DEB synchronised samples all disagree with it. A
  // debounced rise moves the target on the following edge, and duty_cycle is
  // the target.
  // ---------------------------------------------------------------------------
  bit [2:0]   mq [$];
  bit [2:0]   m_deb;
  bit [2:0]   m_rose;
  logic [1:0] m_tgt;
  logic [1:0] m_duty;
  bit         m_lvl;

  task automatic model_edge(input bit rst_low, input bit [2:0] raw);
    logic [1:0] prev;
    bit         all_diff;
    if (rst_low) begin
      mq     = {3'b000, 3'b000};
      m_deb  = '0;
      m_rose = '0;
      m_tgt  = 2'd0;
      m_duty = 2'd0;
      m_lvl  = 1'b0;
      return;
    end
    prev = m_duty;
    if (m_rose[2])      m_tgt = 2'd0;
    else if (m_rose[1]) m_tgt = (m_tgt == 2'd3) ? 2'd3 : m_tgt + 2'd1;
    else if (m_rose[0]) m_tgt = (m_tgt == 2'd0) ? 2'd0 : m_tgt - 2'd1;
    m_duty = m_tgt;
    m_lvl  = (m_duty != prev);
    mq.push_back(raw);
    if (mq.size() > DEB + 4) void'(mq.pop_front());
    m_rose = '0;
    for (int i = 0; i < 3; i++) begin
      if (mq.size() >= DEB + 2) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (mq[mq.size() - 3 - k][i] == m_deb[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_deb[i]  = ~m_deb[i];
          m_rose[i] = m_deb[i];
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Table of clean presses: {up, down, stop, expected settled duty_cycle}
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       up;
    logic       down;
    logic       stop;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Reset held low for 3 cycles with buttons idle, then released.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("rst_hold");
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all_zero("rst_rel");
    end

    // Held press: first sampled at edge E, target updates at E+DEB+2.
    do_reset();
    btn_up = 1'b1;
    for (int idx = 0; idx < 50; idx++) begin
      tick();
      if (!SS) begin
        check("hold_duty", duty_cycle, (idx >= DEB + 2) ? 1 : 0);
        check("hold_lvl", level_chg, (idx == DEB + 2) ? 1 : 0);
        check("hold_busy", busy, 0);
      end else if (idx == DEB + 2) begin
        check("hold_ss_busy", busy, 1);
        check("hold_ss_duty", duty_cycle, 0);
      end
    end
    btn_up = 1'b0;

    // Bounce every 2 cycles never stays stable long enough.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      btn_up = ((i / 2) % 2) == 1;
      tick();
      check("bounce_duty", duty_cycle, 0);
      check("bounce_lvl", level_chg, 0);
    end
    btn_up = 1'b0;

    // Table-driven presses: saturation and simultaneous-press priority.
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 2'd2},
      '{1'b1, 1'b0, 1'b0, 2'd3},
      '{1'b1, 1'b0, 1'b0, 2'd3},
      '{1'b1, 1'b0, 1'b0, 2'd3},
      '{1'b1, 1'b0, 1'b1, 2'd0},
      '{1'b1, 1'b0, 1'b0, 2'd1},
      '{1'b1, 1'b1, 1'b0, 2'd2},
      '{1'b0, 1'b1, 1'b0, 2'd1},
      '{1'b0, 1'b1, 1'b0, 2'd0},
      '{1'b0, 1'b1, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 2'd1},
      '{1'b0, 1'b1, 1'b1, 2'd0},
      '{1'b1, 1'b1, 1'b1, 2'd0}
    };
    do_reset();
    for (int v = 0; v < 14; v++) begin
      btn_up   = tbl[v].up;
      btn_down = tbl[v].down;
      btn_stop = tbl[v].stop;
      repeat (10) tick();
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_stop = 1'b0;
      repeat (12) tick();
      check($sformatf("tbl%0d_duty", v), duty_cycle, tbl[v].exp);
      check($sformatf("tbl%0d_busy", v), busy, 0);
    end

    // Button held across a reset is debounced afresh from 0 after release.
    do_reset();
    btn_up = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("rst_mid_deb");
    reset = 1'b1;
    for (int idx = 0; idx <= DEB + 2; idx++) begin
      tick();
      if (idx == DEB + 1) begin
        check("held_rst_pre_duty", duty_cycle, 0);
        check("held_rst_pre_busy", busy, 0);
      end
    end
    check("held_rst_duty", duty_cycle, SS ? 0 : 1);
    check("held_rst_busy", busy, SS ? 1 : 0);
    btn_up = 1'b0;

    // Partial debounce abandoned by reset leaves no event behind.
    do_reset();
    btn_up = 1'b1;
    repeat (4) tick();
    reset  = 1'b0;
    btn_up = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all_zero("abandon");
    end

`ifdef SPEED_SOFT_START_EN
    // Three presses 8 cycles apart: targets move at idx 6, 14, 22 and
    // duty_cycle steps every RAMP cycles from idx 6.
    do_reset();
    for (int idx = 0; idx < 40; idx++) begin
      btn_up = (idx < 24) && ((idx % 8) < 4);
      tick();
      check("ramp_duty", duty_cycle, (idx < 14) ? 0 : (idx < 22) ? 1 : (idx < 30) ? 2 : 3);
      check("ramp_busy", busy, (idx >= 6 && idx < 30) ? 1 : 0);
      check("ramp_lvl", level_chg, (idx == 14 || idx == 22 || idx == 30) ? 1 : 0);
    end

    // Stop while ramping at duty_cycle 1 drops straight to 0.
    do_reset();
    for (int idx = 0; idx < 30; idx++) begin
      btn_up   = (idx < 16) && ((idx % 8) < 4);
      btn_stop = (idx >= 10) && (idx < 16);
      tick();
      check("stop_ramp_duty", duty_cycle, (idx == 14 || idx == 15) ? 1 : 0);
      check("stop_ramp_busy", busy, (idx >= 6 && idx < 16) ? 1 : 0);
      check("stop_ramp_lvl", level_chg, (idx == 14 || idx == 16) ? 1 : 0);
    end

    // Reset during a ramp clears every output on the next edge.
    do_reset();
    for (int idx = 0; idx < 15; idx++) begin
      btn_up = (idx < 16) && ((idx % 8) < 4);
      tick();
    end
    check("pre_rst_duty", duty_cycle, 1);
    check("pre_rst_busy", busy, 1);
    btn_up = 1'b0;
    reset  = 1'b0;
    tick();
    check_all_zero("rst_ramp");
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all_zero("rst_ramp_after");
    end
`else
    // Random button activity against the reference model.
    begin
      bit [2:0] raw;
      bit       rst_low;
      int       rst_left;
      raw      = '0;
      rst_left = 0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_stop = 1'b0;
      reset    = 1'b0;
      tick();
      model_edge(1'b1, raw);
      tick();
      model_edge(1'b1, raw);
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
        end
        if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = $urandom_range(1, 3);
        rst_low = (rst_left != 0);
        if (rst_left != 0) rst_left--;
        reset    = ~rst_low;
        btn_down = raw[0];
        btn_up   = raw[1];
        btn_stop = raw[2];
        tick();
        model_edge(rst_low, raw);
        check("rnd_duty", duty_cycle, m_duty);
        check("rnd_lvl", level_chg, m_lvl);
        check("rnd_busy", busy, 0);
      end
      reset = 1'b1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
